// File: rtl/video_mixer_out.sv
// Output stage for the scandoubled RGB path: colour expansion, optional mono packing, scanline dimming, DE regeneration.
// Define VMIX_MEASURE_EN to build the active-area measurement counters; otherwise h_active/v_active/meas_valid read 0.
module video_mixer_out #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 8,
    parameter int SL_BITS = 2
) (
    input  logic               clk_vid,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic [SL_BITS-1:0] scanlines,
    input  logic               sl_phase,
    input  logic               mono,
    input  logic [IN_W-1:0]    R,
    input  logic [IN_W-1:0]    G,
    input  logic [IN_W-1:0]    B,
    input  logic               HSync,
    input  logic               VSync,
    input  logic               HBlank,
    input  logic               VBlank,
    output logic [OUT_W-1:0]   VGA_R,
    output logic [OUT_W-1:0]   VGA_G,
    output logic [OUT_W-1:0]   VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_DE,
    output logic [11:0]        h_active,
    output logic [11:0]        v_active,
    output logic               meas_valid
);
    localparam int PW = OUT_W + SL_BITS + 1;
    localparam bit MONO_OK = (2 * IN_W >= OUT_W);
    localparam logic [SL_BITS:0] K_FULL = {1'b1, {SL_BITS{1'b0}}};

    logic [IN_W-1:0]   ch_in [3];
    logic [OUT_W-1:0]  c_next [3];
    logic [OUT_W-1:0]  c_reg [3];
    logic [OUT_W-1:0]  vga_c [3];
    logic [4*IN_W-1:0] mono_word;

    logic hs_prev, vs_prev, hb_prev;
    logic line_flag, de_reg, de_next;
    logic hs_fall, vs_fall, hb_fall, hb_rise;
    logic dim;
    logic [SL_BITS:0] k;

    assign ch_in[0]  = R;
    assign ch_in[1]  = G;
    assign ch_in[2]  = B;
    assign mono_word = {G, R, G, R};

    assign hs_fall = hs_prev & ~HSync;
    assign vs_fall = vs_prev & ~VSync;
    assign hb_fall = hb_prev & ~HBlank;
    assign hb_rise = ~hb_prev & HBlank;

    // VBlank is only looked at on the HBlank fall, so a mid-line change cannot alter the current line
    always_comb begin
        de_next = de_reg;
        if (hb_fall)
            de_next = ~VBlank;
        else if (hb_rise)
            de_next = 1'b0;
    end

    assign dim = (line_flag ^ sl_phase) && (scanlines != '0);
    assign k   = dim ? (K_FULL - {1'b0, scanlines}) : K_FULL;

    // The sync sample registers double as the first pipeline stage for HS/VS
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            hb_prev   <= 1'b0;
            line_flag <= 1'b0;
            de_reg    <= 1'b0;
            VGA_HS    <= 1'b0;
            VGA_VS    <= 1'b0;
            VGA_DE    <= 1'b0;
        end else begin
            hs_prev <= HSync;
            vs_prev <= VSync;
            hb_prev <= HBlank;
            if (vs_fall)
                line_flag <= 1'b0;
            else if (hs_fall)
                line_flag <= ~line_flag;
            de_reg <= de_next;
            VGA_HS <= hs_prev;
            VGA_VS <= vs_prev;
            VGA_DE <= de_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [3*IN_W-1:0] rep;
            assign rep = {3{ch_in[gi]}};
            assign c_next[gi] = (MONO_OK && mono) ? mono_word[4*IN_W-1 -: OUT_W]
                                                  : rep[3*IN_W-1 -: OUT_W];

            // k never exceeds 2^SL_BITS, so the shifted product always fits OUT_W
            always_ff @(posedge clk_vid or negedge reset_n) begin
                if (!reset_n) begin
                    c_reg[gi] <= '0;
                    vga_c[gi] <= '0;
                end else begin
                    c_reg[gi] <= c_next[gi];
                    vga_c[gi] <= OUT_W'((PW'(c_reg[gi]) * PW'(k)) >> SL_BITS);
                end
            end
        end
    endgenerate

    assign VGA_R = vga_c[0];
    assign VGA_G = vga_c[1];
    assign VGA_B = vga_c[2];

`ifdef VMIX_MEASURE_EN
    logic [11:0] hcnt, vcnt;
    logic        de_prev;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            hcnt       <= '0;
            vcnt       <= '0;
            de_prev    <= 1'b0;
            h_active   <= '0;
            v_active   <= '0;
            meas_valid <= 1'b0;
        end else begin
            de_prev    <= de_reg;
            meas_valid <= 1'b0;
            if (de_prev && !de_reg) begin
                h_active <= hcnt;
                hcnt     <= '0;
            end else if (ce_pix && de_reg && hcnt != 12'hFFF) begin
                hcnt <= hcnt + 12'd1;
            end
            if (!vs_prev && VSync) begin
                v_active   <= vcnt;
                vcnt       <= '0;
                meas_valid <= 1'b1;
            end else if (!de_prev && de_reg && vcnt != 12'hFFF) begin
                vcnt <= vcnt + 12'd1;
            end
        end
    end
`else
    wire unused_ce_pix = ce_pix;
    assign h_active   = '0;
    assign v_active   = '0;
    assign meas_valid = 1'b0;
`endif

endmodule
